// File: rtl/xor_inv_pkg.sv
// Shared constants and the per-stage lane inverse for the XOR/invert decode pipeline.
// No ports; imported by xor_inv_pipe_if, xor_inv_stage and xor_inv_pipe.
// The XOR_INV_PARITY_EN macro does not affect this file.
package xor_inv_pkg;

  localparam int IO_PAIRS_DEF = 6;   // number of 2-bit lanes
  localparam int DEPTH_DEF    = 1;   // inverse stages / pipeline registers (1..16)
  localparam int CNT_W        = 16;  // delivered-word counter width
  localparam int MAX_W        = 128; // widest word the inverse helper handles (64 lanes)

  // One inverse stage over every 2-bit lane: bit0 is inverted, bit1 is
  // XORed with the inverted bit0. Lanes are independent, so callers
  // zero-extend narrower words and keep only their low bits.
  function automatic logic [MAX_W-1:0] inv_word(input logic [MAX_W-1:0] x);
    logic [MAX_W-1:0] d;
    d = '0;
    for (int j = 0; j < MAX_W / 2; j++) begin
      d[2*j]   = ~x[2*j];
      d[2*j+1] = x[2*j+1] ^ ~x[2*j];
    end
    return d;
  endfunction

endpackage

// File: rtl/xor_inv_pipe_if.sv
// Handshake bundle for xor_inv_pipe: input stream (in_valid/in_ready/in_data) and
// output stream (out_valid/out_ready/out_data). With XOR_INV_PARITY_EN defined it also
// carries in_parity (even parity over in_data), out_perr and perr_sticky.
// slave modport = the pipeline; master modport = the surrounding producer/consumer.
interface xor_inv_pipe_if
  import xor_inv_pkg::*;
#(
  parameter int W = 2 * IO_PAIRS_DEF
);

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
`ifdef XOR_INV_PARITY_EN
  logic         in_parity;
  logic         out_perr;
  logic         perr_sticky;
`endif

  modport slave (
    input  in_valid,
    output in_ready,
    input  in_data,
    output out_valid,
    input  out_ready,
    output out_data
`ifdef XOR_INV_PARITY_EN
    ,
    input  in_parity,
    output out_perr,
    output perr_sticky
`endif
  );

  modport master (
    output in_valid,
    input  in_ready,
    output in_data,
    input  out_valid,
    output out_ready,
    input  out_data
`ifdef XOR_INV_PARITY_EN
    ,
    output in_parity,
    input  out_perr,
    input  perr_sticky
`endif
  );

endinterface

// File: rtl/xor_inv_stage.sv
// One register stage: applies a single lane-inverse to the upstream word and holds it with a valid bit.
// Latency 1 cycle. Loads whenever empty or when downstream takes the held word (dn_rdy_i).
// Ports: clk, rst (sync, active-high); up_vld_i/up_dat_i in; dn_rdy_i in; dn_vld_o/dn_dat_o out.
// XOR_INV_PARITY_EN adds up_perr_i/dn_perr_o, a parity-error flag riding with the word.
module xor_inv_stage
  import xor_inv_pkg::*;
#(
  parameter int W = 2 * IO_PAIRS_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         up_vld_i,
  input  logic [W-1:0] up_dat_i,
`ifdef XOR_INV_PARITY_EN
  input  logic         up_perr_i,
  output logic         dn_perr_o,
`endif
  input  logic         dn_rdy_i,
  output logic         dn_vld_o,
  output logic [W-1:0] dn_dat_o
);

  logic         adv;
  logic         vld_q, vld_d;
  logic [W-1:0] dat_q, dat_d;

  // The stage may take a new word when it is empty or its word leaves this cycle.
  // The parent derives the upstream ready from the same condition.
  assign adv   = !vld_q || dn_rdy_i;
  assign vld_d = adv ? up_vld_i : vld_q;
  assign dat_d = (adv && up_vld_i) ? W'(inv_word(MAX_W'(up_dat_i))) : dat_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= 1'b0;
    end else begin
      vld_q <= vld_d;
    end
  end

  // Data is qualified by vld_q, so it needs no reset.
  always_ff @(posedge clk) begin
    dat_q <= dat_d;
  end

  assign dn_vld_o = vld_q;
  assign dn_dat_o = dat_q;

`ifdef XOR_INV_PARITY_EN
  logic perr_q, perr_d;

  assign perr_d = (adv && up_vld_i) ? up_perr_i : perr_q;

  always_ff @(posedge clk) begin
    perr_q <= perr_d;
  end

  assign dn_perr_o = perr_q;
`endif

endmodule

// File: rtl/xor_inv_pipe.sv
// Decodes words produced by a DEPTH-stage 2-bit-lane XOR/invert transform.
// Latency DEPTH cycles, 1 word/cycle throughput; out_data comes straight from the last register.
// Backpressure: out_ready low stalls the chain from the output back; held words stay stable.
// Ports: clk, rst (sync, active-high); bus (xor_inv_pipe_if.slave); word_count (delivered words, wraps).
// XOR_INV_PARITY_EN adds in_parity / out_perr / perr_sticky on the bus.
// IO_PAIRS up to 64; DEPTH legal range 1..16.
module xor_inv_pipe
  import xor_inv_pkg::*;
#(
  parameter int IO_PAIRS = IO_PAIRS_DEF,
  parameter int DEPTH    = DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  xor_inv_pipe_if.slave    bus,
  output logic [CNT_W-1:0] word_count
);

  localparam int W = 2 * IO_PAIRS;

  // Index 0 is the input port, index k+1 is the output of stage k.
  logic [DEPTH:0] s_vld;
  logic [W-1:0]   s_dat [DEPTH+1];
  logic [DEPTH:0] s_rdy;

  assign s_vld[0] = bus.in_valid;
  assign s_dat[0] = bus.in_data;

  // Ready chain built from the registered valids: a stage can accept when it
  // is empty or everything downstream of it advances. Computing it in one
  // place keeps it a straight combinational path from out_ready.
  always_comb begin
    s_rdy        = '0;
    s_rdy[DEPTH] = bus.out_ready;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      s_rdy[k] = !s_vld[k+1] || s_rdy[k+1];
    end
  end

`ifdef XOR_INV_PARITY_EN
  logic [DEPTH:0] s_perr;

  // Even parity: data bits plus parity bit must XOR to zero.
  assign s_perr[0] = ^{bus.in_data, bus.in_parity};
`endif

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    xor_inv_stage #(
      .W (W)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .up_vld_i (s_vld[k]),
      .up_dat_i (s_dat[k]),
`ifdef XOR_INV_PARITY_EN
      .up_perr_i(s_perr[k]),
      .dn_perr_o(s_perr[k+1]),
`endif
      .dn_rdy_i (s_rdy[k+1]),
      .dn_vld_o (s_vld[k+1]),
      .dn_dat_o (s_dat[k+1])
    );
  end

  // in_ready is forced low during reset so nothing is accepted then.
  assign bus.in_ready  = !rst && s_rdy[0];
  assign bus.out_valid = s_vld[DEPTH];
  assign bus.out_data  = s_dat[DEPTH];

  logic             out_xfer;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign out_xfer = s_vld[DEPTH] && bus.out_ready;
  assign cnt_d    = out_xfer ? cnt_q + CNT_W'(1) : cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign word_count = cnt_q;

`ifdef XOR_INV_PARITY_EN
  logic sticky_q, sticky_d;

  assign bus.out_perr = s_vld[DEPTH] && s_perr[DEPTH];
  assign sticky_d     = sticky_q || (out_xfer && s_perr[DEPTH]);

  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_q <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign bus.perr_sticky = sticky_q;
`endif

endmodule

// File: tb/tb_xor_inv_pipe.sv
// Self-checking bench for xor_inv_pipe: a DEPTH=1 and a DEPTH=2 instance (IO_PAIRS=6).
// Inputs are driven and outputs sampled on the falling clock edge.
// With XOR_INV_PARITY_EN defined the parity ports are exercised as well.
module tb_xor_inv_pipe;
  import xor_inv_pkg::*;

  localparam int W = 12;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  xor_inv_pipe_if #(.W(W)) bus1 ();
  xor_inv_pipe_if #(.W(W)) bus2 ();

  logic [CNT_W-1:0] wc1, wc2;

  xor_inv_pipe #(.IO_PAIRS(6), .DEPTH(1)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus1),
    .word_count(wc1)
  );

  xor_inv_pipe #(.IO_PAIRS(6), .DEPTH(2)) dut2 (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus2),
    .word_count(wc2)
  );

`ifdef XOR_INV_PARITY_EN
  logic bad1 = 1'b0;
  logic bad2 = 1'b0;
  assign bus1.in_parity = ^bus1.in_data ^ bad1;
  assign bus2.in_parity = ^bus2.in_data ^ bad2;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Forward transform of one stage (the encoder the pipeline undoes).
  function automatic logic [W-1:0] enc1(input logic [W-1:0] p);
    logic [W-1:0] e;
    for (int j = 0; j < W / 2; j++) begin
      e[2*j]   = ~p[2*j];
      e[2*j+1] = p[2*j+1] ^ p[2*j];
    end
    return e;
  endfunction

  // Streams n random words through the DEPTH=2 instance with out_ready high pct% of cycles.
  task automatic run_stream(input int n, input int pct, input string tag,
                            output int cyc_o, output int stall_o);
    logic [W-1:0] exp_q[$];
    logic [W-1:0] cur;
    logic [W-1:0] prev_dat;
    logic         prev_stall;
    int sent, recv, cyc, in_stall;
    sent = 0; recv = 0; cyc = 0; in_stall = 0;
    prev_stall = 1'b0;
    prev_dat   = '0;
    cur        = W'($urandom);
    while (recv < n && cyc < 20 * n + 100) begin
      if (prev_stall) begin
        check_eq({tag, "_hold_vld"}, 32'(bus2.out_valid), 32'd1);
        check_eq({tag, "_hold_dat"}, 32'(bus2.out_data), 32'(prev_dat));
      end
      bus2.out_ready = ($urandom_range(0, 99) < pct);
      bus2.in_valid  = (sent < n);
      bus2.in_data   = enc1(enc1(cur));
      #1;
      if (bus2.out_valid && bus2.out_ready) begin
        check_eq({tag, "_nonempty"}, 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          check_eq({tag, "_dat"}, 32'(bus2.out_data), 32'(exp_q.pop_front()));
        end
        recv++;
      end
      if (bus2.in_valid && bus2.in_ready) begin
        exp_q.push_back(cur);
        sent++;
        cur = W'($urandom);
      end else if (bus2.in_valid) begin
        in_stall++;
      end
      prev_stall = bus2.out_valid && !bus2.out_ready;
      prev_dat   = bus2.out_data;
      step();
      cyc++;
    end
    bus2.in_valid  = 1'b0;
    bus2.out_ready = 1'b0;
    check_eq({tag, "_recv"}, 32'(recv), 32'(n));
    check_eq({tag, "_sent"}, 32'(sent), 32'(n));
    check_eq({tag, "_leftover"}, 32'(exp_q.size()), 32'd0);
    cyc_o   = cyc;
    stall_o = in_stall;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int cyc, stalls, hits;

    rst            = 1'b1;
    bus1.in_valid  = 1'b0; bus1.in_data = '0; bus1.out_ready = 1'b0;
    bus2.in_valid  = 1'b0; bus2.in_data = '0; bus2.out_ready = 1'b0;
    repeat (3) step();

    // Reset state
    check_eq("rst_in_ready1",  32'(bus1.in_ready),  32'd0);
    check_eq("rst_in_ready2",  32'(bus2.in_ready),  32'd0);
    check_eq("rst_out_valid1", 32'(bus1.out_valid), 32'd0);
    check_eq("rst_out_valid2", 32'(bus2.out_valid), 32'd0);
    check_eq("rst_wc1",        32'(wc1),            32'd0);
    check_eq("rst_wc2",        32'(wc2),            32'd0);
    rst = 1'b0;
    #1;
    check_eq("post_rst_in_ready1", 32'(bus1.in_ready), 32'd1);
    check_eq("post_rst_in_ready2", 32'(bus2.in_ready), 32'd1);

    // DEPTH=1 directed vectors
    bus1.out_ready = 1'b1;
    bus1.in_valid  = 1'b1;
    bus1.in_data   = 12'h555;
    step();
    check_eq("d1_555_vld", 32'(bus1.out_valid), 32'd1);
    check_eq("d1_555_dat", 32'(bus1.out_data),  32'h000);
    bus1.in_data = 12'hFFF;
    step();
    check_eq("d1_fff_vld", 32'(bus1.out_valid), 32'd1);
    check_eq("d1_fff_dat", 32'(bus1.out_data),  32'hAAA);
    bus1.in_valid = 1'b0;
    step();
    check_eq("d1_idle_vld", 32'(bus1.out_valid), 32'd0);
    check_eq("d1_wc",       32'(wc1),            32'd2);

    // DEPTH=2 directed vectors
    bus2.out_ready = 1'b1;
    bus2.in_valid  = 1'b1;
    bus2.in_data   = 12'hAAA;
    step();
    check_eq("d2_lat1_vld", 32'(bus2.out_valid), 32'd0);
    bus2.in_data = 12'h555;
    step();
    check_eq("d2_aaa_vld", 32'(bus2.out_valid), 32'd1);
    check_eq("d2_aaa_dat", 32'(bus2.out_data),  32'h000);
    bus2.in_valid = 1'b0;
    step();
    check_eq("d2_555_vld", 32'(bus2.out_valid), 32'd1);
    check_eq("d2_555_dat", 32'(bus2.out_data),  32'hFFF);
    step();
    check_eq("d2_idle_vld", 32'(bus2.out_valid), 32'd0);
    check_eq("d2_wc",       32'(wc2),            32'd2);

    // Clean counters, then streams through DEPTH=2
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    run_stream(1000, 100, "stream", cyc, stalls);
    check_eq("stream_in_stalls", 32'(stalls), 32'd0);
    check_eq("stream_cycles",    32'(cyc),    32'd1002);
    check_eq("stream_wc",        32'(wc2),    32'd1000);

    run_stream(200, 30, "bp", cyc, stalls);
    check_eq("bp_wc", 32'(wc2), 32'd1200);

    // Reset mid-stream with 3 words in flight (2 held, 1 presented)
    bus2.out_ready = 1'b0;
    bus2.in_valid  = 1'b1;
    bus2.in_data   = enc1(enc1(12'h101));
    step();
    bus2.in_data   = enc1(enc1(12'h102));
    step();
    bus2.in_data   = enc1(enc1(12'h103));
    #1;
    check_eq("mid_full_in_ready", 32'(bus2.in_ready),  32'd0);
    check_eq("mid_full_out_vld",  32'(bus2.out_valid), 32'd1);
    rst = 1'b1;
    step();
    check_eq("mid_rst_out_vld",  32'(bus2.out_valid), 32'd0);
    check_eq("mid_rst_wc",       32'(wc2),            32'd0);
    check_eq("mid_rst_in_ready", 32'(bus2.in_ready),  32'd0);
    rst            = 1'b0;
    bus2.in_valid  = 1'b0;
    bus2.out_ready = 1'b1;
    #1;
    check_eq("mid_post_in_ready", 32'(bus2.in_ready), 32'd1);
    hits = 0;
    repeat (8) begin
      step();
      if (bus2.out_valid) hits++;
    end
    check_eq("mid_no_old_words", 32'(hits), 32'd0);
    check_eq("mid_wc_after",     32'(wc2),  32'd0);
    bus2.out_ready = 1'b0;

    // Counter wrap on DEPTH=1 (counter cleared by the reset above)
    bus1.out_ready = 1'b1;
    bus1.in_valid  = 1'b1;
    bus1.in_data   = 12'h123;
    repeat (65535) step();
    bus1.in_valid = 1'b0;
    repeat (3) step();
    check_eq("wrap_ffff", 32'(wc1), 32'h0000FFFF);
    bus1.in_valid = 1'b1;
    step();
    bus1.in_valid = 1'b0;
    repeat (3) step();
    check_eq("wrap_zero", 32'(wc1), 32'h00000000);

`ifdef XOR_INV_PARITY_EN
    // Parity error on only the middle word
    check_eq("perr_sticky_init", 32'(bus1.perr_sticky), 32'd0);
    bus1.in_valid = 1'b1;
    bus1.in_data  = 12'h0F0;
    bad1          = 1'b0;
    step();
    check_eq("perr_w0",        32'(bus1.out_perr),    32'd0);
    check_eq("perr_w0_sticky", 32'(bus1.perr_sticky), 32'd0);
    bus1.in_data = 12'h3C3;
    bad1         = 1'b1;
    step();
    check_eq("perr_w1_vld", 32'(bus1.out_valid), 32'd1);
    check_eq("perr_w1",     32'(bus1.out_perr),  32'd1);
    bus1.in_data = 12'h5A5;
    bad1         = 1'b0;
    step();
    check_eq("perr_w2",        32'(bus1.out_perr),    32'd0);
    check_eq("perr_w2_sticky", 32'(bus1.perr_sticky), 32'd1);
    bus1.in_valid = 1'b0;
    repeat (4) step();
    check_eq("perr_idle",        32'(bus1.out_perr),    32'd0);
    check_eq("perr_sticky_hold", 32'(bus1.perr_sticky), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check_eq("perr_sticky_rst", 32'(bus1.perr_sticky), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/xor_inv_pipe.md
XOR_INV_PIPE -- requirements
Module: xor_inv_pipe

Interface
REQ-001 Parameter: IO_PAIRS, default 6, number of 2-bit lanes; data width W = 2*IO_PAIRS.
REQ-002 Parameter: DEPTH, default 1, number of inverse stages and pipeline registers; legal range 1..16.
REQ-003 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port: rst  input  1  reset, synchronous and active-high.
REQ-005 Port: in_valid  input  1  upstream word valid.
REQ-006 Port: in_ready  output  1  block accepts the word this cycle.
REQ-007 Port: in_data  input  W  encoded word, produced by the DEPTH-stage pair transform.
REQ-008 Port: out_valid  output  1  decoded word valid.
REQ-009 Port: out_ready  input  1  downstream accepts the word this cycle.
REQ-010 Port: out_data  output  W  decoded word.
REQ-011 Port: word_count  output  16  number of words delivered on the output.

Function
REQ-012 Per-lane inverse, per stage, for lane j: d[2j] = ~x[2j]; d[2j+1] = x[2j+1] ^ ~x[2j].
REQ-013 Stage k (0..DEPTH-1) applies the REQ-012 inverse to the stage k-1 register (in_data for k=0) and registers the result with a valid bit.
REQ-014 out_data/out_valid are driven directly from the stage DEPTH-1 register; no combinational path from in_data to out_data.
REQ-015 Input transfer occurs when in_valid && in_ready; output transfer occurs when out_valid && out_ready.
REQ-016 Stage k advances when its register is empty or the downstream stage advances (out_ready for the last stage).
REQ-017 in_ready = !valid[0] || advance[0]; full throughput of 1 word/cycle with out_ready held high.
REQ-018 Latency: exactly DEPTH cycles from input transfer to out_valid when there is no backpressure.
REQ-019 Under backpressure, out_data and out_valid stay stable until transferred; no word is dropped or duplicated; order is preserved.
REQ-020 With the pipeline full and out_ready=1, a simultaneous input transfer and output transfer in the same cycle are both legal.
REQ-021 word_count increments by 1 on each output transfer and wraps from 16'hFFFF to 16'h0000.

Reset
REQ-022 While rst=1: all stage valid bits are 0, out_valid=0, word_count=0, in_ready=0.
REQ-023 Data registers need not be reset; out_data is don't-care while out_valid=0.
REQ-024 Reset asserted mid-stream discards all in-flight words; in_ready=1 on the first cycle after rst deasserts.

Configuration
REQ-025 Macro XOR_INV_PARITY_EN, when defined, adds input in_parity (1 bit, even parity over in_data) and outputs out_perr (1 bit) and perr_sticky (1 bit).
REQ-026 With XOR_INV_PARITY_EN defined: the parity mismatch is computed at input transfer and travels with the word; out_perr is qualified by out_valid; perr_sticky sets on the first output transfer with out_perr=1 and clears only on rst.
REQ-027 Without XOR_INV_PARITY_EN: none of those three ports exist and the logic is identical otherwise.

Structure
REQ-028 Package xor_inv_pkg holds the IO_PAIRS/DEPTH defaults, the 16-bit count width constant, and a function applying one REQ-012 inverse stage to a W-bit word.
REQ-029 Sub-module xor_inv_stage: one valid/ready register stage (data, valid, optional parity flag), instantiated DEPTH times in a generate loop.

Verification
REQ-030 IO_PAIRS=6, DEPTH=1, out_ready=1: in_data 12'h555 -> out_data 12'h000 one cycle after transfer; 12'hFFF -> 12'hAAA.
REQ-031 DEPTH=2: in_data 12'hAAA -> out_data 12'h000 after 2 cycles; a stream of 1000 random words encoded by a bench model decodes to the originals, in order.
REQ-032 Backpressure: random out_ready at 30% high with a full pipeline -> no loss or duplication, out_data stable while stalled, word_count equals the accepted count.
REQ-033 Reset mid-stream with 3 words in flight -> out_valid=0 the next cycle, word_count=0, and the old words never appear on the output.
REQ-034 Wrap: preload 65535 transfers, then 1 more -> word_count=16'h0000.
REQ-035 XOR_INV_PARITY_EN defined: one word with wrong in_parity -> out_perr=1 on only that word; perr_sticky stays 1 until rst.
